// File: rtl/m3_sliceperiodgen_pkg.sv
// Shared constants and helpers for the motor-3 slice period generator.
// The speed calculator imports the same package, so both agree on the period limits.
package m3_sliceperiodgen_pkg;

    // Longest slice period in clkI cycles; also the idle/reset period.
    localparam logic [31:0] eachSlicePeriodMax = 32'd2_000_000;
    // Shortest slice period in clkI cycles.
    localparam logic [31:0] clkPeriodMin       = 32'd40;
    // Highest commutation phase index in one electrical round.
    localparam logic [2:0]  phaseLast          = 3'd5;

    // Next commutation phase: +1 mod 6 forward, -1 mod 6 in reverse.
    function automatic logic [2:0] phaseStep(input logic [2:0] phase, input logic reverse);
        logic [2:0] nextPhase;
        if (reverse) begin
            nextPhase = (phase == 3'd0) ? phaseLast : phase - 3'd1;
        end else begin
            nextPhase = (phase == phaseLast) ? 3'd0 : phase + 3'd1;
        end
        return nextPhase;
    endfunction

endpackage

// File: rtl/m3_sliceperiodgen_if.sv
// Control/status bundle between the speed calculator, this generator and the phase stage.
// Inputs are level signals sampled on every clkI edge; the *_1O outputs are single-cycle
// pulses, the remaining outputs are registered levels. There is no backpressure.
interface m3_sliceperiodgen_if;
    logic        workingI;
    logic        m3forceStopI;
    logic        m3invRotateI;
    logic [31:0] dstRoundLenI;
    logic        nextCalc_1O;
    logic        sliceTick_1O;
    logic [2:0]  phaseIdxO;
    logic        driveEnO;
    logic [31:0] curPeriodO;
    logic [1:0]  stateDbgO;

    modport master (
        output workingI, m3forceStopI, m3invRotateI, dstRoundLenI,
        input  nextCalc_1O, sliceTick_1O, phaseIdxO, driveEnO, curPeriodO, stateDbgO
    );

    modport slave (
        input  workingI, m3forceStopI, m3invRotateI, dstRoundLenI,
        output nextCalc_1O, sliceTick_1O, phaseIdxO, driveEnO, curPeriodO, stateDbgO
    );
endinterface

// File: rtl/m3_sliceperiodgen_clamp.sv
// Combinational clamp of a requested slice period into the legal range.
module m3_periodClamp
    import m3_sliceperiodgen_pkg::*;
(
    input  logic [31:0] lenI,
    output logic [31:0] periodO
);

    // Unsigned 32-bit limit against both bounds.
    always_comb begin
        periodO = lenI;
        if (lenI < clkPeriodMin) begin
            periodO = clkPeriodMin;
        end else if (lenI > eachSlicePeriodMax) begin
            periodO = eachSlicePeriodMax;
        end
    end

endmodule

// File: rtl/m3_sliceperiodgen.sv
// Motor-3 commutation slice timer: splits clkI into six-slice electrical rounds,
// steps the phase index and pulses nextCalc_1O once per completed round.
module m3_sliceperiodgen
    import m3_sliceperiodgen_pkg::*;
(
    input  logic                  clkI,
    input  logic                  nRstI,
    m3_sliceperiodgen_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  phaseIdx;
    logic [2:0]  roundCnt;
    logic        dirRev;
    logic [31:0] sliceCnt;
    logic [31:0] curPeriod;
    logic        sliceTick;
    logic        nextCalc;
    logic        driveEn;
    logic [31:0] clampedLen;
    logic        dirMatch;

    m3_periodClamp uClamp (
        .lenI    (bus.dstRoundLenI),
        .periodO (clampedLen)
    );

    // A requested direction equal to the latched one keeps commutating; otherwise a dead slice follows.
    assign dirMatch = (bus.m3invRotateI == dirRev);

    // Single state register process: run enable beats stop, stop beats normal slice sequencing.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state     <= IDLE;
            phaseIdx  <= 3'd0;
            roundCnt  <= 3'd0;
            dirRev    <= 1'b0;
            sliceCnt  <= 32'd0;
            curPeriod <= eachSlicePeriodMax;
            sliceTick <= 1'b0;
            nextCalc  <= 1'b0;
            driveEn   <= 1'b0;
        end else begin
            sliceTick <= 1'b0;
            nextCalc  <= 1'b0;
            if (!bus.workingI || (state == STOP && !bus.m3forceStopI)) begin
                // Disabled, or leaving STOP: every restart begins from phase 0.
                state     <= IDLE;
                phaseIdx  <= 3'd0;
                roundCnt  <= 3'd0;
                sliceCnt  <= 32'd0;
                curPeriod <= eachSlicePeriodMax;
                dirRev    <= bus.m3invRotateI;
                driveEn   <= 1'b0;
            end else if (bus.m3forceStopI) begin
                state    <= STOP;
                sliceCnt <= 32'd0;
                driveEn  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= RUN;
                        curPeriod <= clampedLen;
                        sliceCnt  <= clampedLen - 32'd1;
                        dirRev    <= bus.m3invRotateI;
                        driveEn   <= 1'b1;
                    end
                    RUN, DEAD: begin
                        if (sliceCnt != 32'd0) begin
                            sliceCnt <= sliceCnt - 32'd1;
                        end else begin
                            // Slice boundary: latch the next period and reload the down-counter.
                            sliceTick <= 1'b1;
                            curPeriod <= clampedLen;
                            sliceCnt  <= clampedLen - 32'd1;
                            if (state == DEAD) begin
                                state    <= RUN;
                                dirRev   <= bus.m3invRotateI;
                                roundCnt <= 3'd0;
                                driveEn  <= 1'b1;
                            end else if (dirMatch) begin
                                phaseIdx <= phaseStep(phaseIdx, dirRev);
                                if (roundCnt == phaseLast) begin
                                    roundCnt <= 3'd0;
                                    nextCalc <= 1'b1;
                                end else begin
                                    roundCnt <= roundCnt + 3'd1;
                                end
                            end else begin
                                state   <= DEAD;
                                driveEn <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state   <= STOP;
                        driveEn <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.nextCalc_1O  = nextCalc;
    assign bus.sliceTick_1O = sliceTick;
    assign bus.phaseIdxO    = phaseIdx;
    assign bus.driveEnO     = driveEn;
    assign bus.curPeriodO   = curPeriod;
    assign bus.stateDbgO    = state;

endmodule

// File: tb/tb_m3_sliceperiodgen.sv
// Bench for the motor-3 slice period generator.
module tb_m3_sliceperiodgen;
    import m3_sliceperiodgen_pkg::*;

    // ---------------- clock / reset ----------------
    logic clkI  = 1'b0;
    logic nRstI = 1'b0;
    always #5 clkI = ~clkI;

    m3_sliceperiodgen_if bus();

    m3_sliceperiodgen dut (
        .clkI  (clkI),
        .nRstI (nRstI),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int vecCnt = 0;
    int errCnt = 0;
    logic [37:0] exp_q[$];

    localparam logic [37:0] resetVec = {1'b0, 1'b0, 3'd0, 1'b0, 32'd2_000_000};

    // Reference model: slice position counted upward, modes as plain ints.
    localparam int mIdle = 0;
    localparam int mRun  = 1;
    localparam int mDead = 2;
    localparam int mStop = 3;

    int          mMode;
    int          mElapsed;
    int          mPhase;
    int          mRound;
    logic [31:0] mPeriod;
    logic        mDir;
    logic        mDrive;
    logic        mTick;
    logic        mNext;

    typedef struct {
        logic [31:0] len;
        logic [31:0] expPeriod;
    } clampVec_t;

    clampVec_t clampTbl[10];

    function automatic logic [31:0] refClamp(input logic [31:0] v);
        if (v < 32'd40) return 32'd40;
        if (v > eachSlicePeriodMax) return eachSlicePeriodMax;
        return v;
    endfunction

    function automatic logic [37:0] actualVec();
        return {bus.nextCalc_1O, bus.sliceTick_1O, bus.phaseIdxO, bus.driveEnO, bus.curPeriodO};
    endfunction

    function automatic logic [37:0] modelVec();
        return {mNext, mTick, 3'(mPhase), mDrive, mPeriod};
    endfunction

    task automatic checkVec(input string name, input logic [37:0] act, input logic [37:0] exp);
        vecCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s t=%0t: got {nc,tick,phase,drv,period}=%h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic modelGoIdle();
        mMode    = mIdle;
        mPhase   = 0;
        mRound   = 0;
        mElapsed = 0;
        mPeriod  = eachSlicePeriodMax;
        mDrive   = 1'b0;
    endtask

    task automatic modelReset();
        modelGoIdle();
        mDir  = 1'b0;
        mTick = 1'b0;
        mNext = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelStep();
        mTick = 1'b0;
        mNext = 1'b0;
        if (!bus.workingI || (mMode == mStop && !bus.m3forceStopI)) begin
            modelGoIdle();
            mDir = bus.m3invRotateI;
        end else if (bus.m3forceStopI) begin
            mMode    = mStop;
            mElapsed = 0;
            mDrive   = 1'b0;
        end else if (mMode == mIdle) begin
            mMode    = mRun;
            mPeriod  = refClamp(bus.dstRoundLenI);
            mElapsed = 0;
            mDrive   = 1'b1;
            mDir     = bus.m3invRotateI;
        end else begin
            mElapsed++;
            if (mElapsed == int'(mPeriod)) begin
                mTick    = 1'b1;
                mElapsed = 0;
                if (mMode == mDead) begin
                    mMode  = mRun;
                    mDir   = bus.m3invRotateI;
                    mRound = 0;
                    mDrive = 1'b1;
                end else if (bus.m3invRotateI == mDir) begin
                    mPhase = mDir ? (mPhase + 5) % 6 : (mPhase + 1) % 6;
                    mRound = (mRound + 1) % 6;
                    mNext  = (mRound == 0);
                end else begin
                    mMode  = mDead;
                    mDrive = 1'b0;
                end
                mPeriod = refClamp(bus.dstRoundLenI);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        logic [37:0] exp;
        modelStep();
        exp_q.push_back(modelVec());
        @(posedge clkI);
        @(negedge clkI);
        exp = exp_q.pop_front();
        checkVec("cycle", actualVec(), exp);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Step until the model sits in RUN at the given slice position (and phase, if >= 0).
    task automatic waitRunAt(input int elapsed, input int phase, input int budget);
        int  n = 0;
        bit  hit;
        hit = (mMode == mRun && mElapsed == elapsed && (phase < 0 || mPhase == phase));
        while (!hit && n < budget) begin
            cycle();
            n++;
            hit = (mMode == mRun && mElapsed == elapsed && (phase < 0 || mPhase == phase));
        end
        vecCnt++;
        if (!hit) begin
            errCnt++;
            $display("FAIL wait: RUN position %0d phase %0d not reached in %0d cycles", elapsed, phase, budget);
        end
    endtask

    task automatic setInputs(input logic w, input logic s, input logic inv, input logic [31:0] len);
        bus.workingI     = w;
        bus.m3forceStopI = s;
        bus.m3invRotateI = inv;
        bus.dstRoundLenI = len;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        clampTbl[0] = '{32'd10,         32'd40};
        clampTbl[1] = '{32'd0,          32'd40};
        clampTbl[2] = '{32'd39,         32'd40};
        clampTbl[3] = '{32'd40,         32'd40};
        clampTbl[4] = '{32'd41,         32'd41};
        clampTbl[5] = '{32'd100,        32'd100};
        clampTbl[6] = '{32'd1_999_999,  32'd1_999_999};
        clampTbl[7] = '{32'd2_000_000,  32'd2_000_000};
        clampTbl[8] = '{32'd2_000_001,  32'd2_000_000};
        clampTbl[9] = '{32'hFFFF_FFFF,  32'd2_000_000};

        setInputs(1'b0, 1'b0, 1'b0, 32'd100);
        modelReset();
        repeat (3) @(negedge clkI);
        checkVec("reset", actualVec(), resetVec);
        nRstI = 1'b1;
        runCycles(2);

        // Clamp table: each entry starts a fresh run and checks the latched period.
        for (int i = 0; i < 10; i++) begin
            setInputs(1'b0, 1'b0, 1'b0, clampTbl[i].len);
            runCycles(1);
            bus.workingI = 1'b1;
            runCycles(1);
            checkVec("clamp", {5'd0, bus.driveEnO, bus.curPeriodO}, {5'd0, 1'b1, clampTbl[i].expPeriod});
        end
        setInputs(1'b0, 1'b0, 1'b0, 32'd100);
        runCycles(2);

        // Basic timing: two full rounds at period 100.
        bus.workingI = 1'b1;
        runCycles(1300);

        // Mid-slice period change at position 50.
        waitRunAt(50, -1, 200);
        bus.dstRoundLenI = 32'd60;
        runCycles(300);
        bus.dstRoundLenI = 32'd100;
        runCycles(200);

        // Direction reversal while in phase 3.
        waitRunAt(10, 3, 800);
        bus.m3invRotateI = 1'b1;
        runCycles(1500);
        bus.m3invRotateI = 1'b0;
        runCycles(800);

        // Force stop 30 cycles into a slice, then release.
        waitRunAt(30, -1, 200);
        bus.m3forceStopI = 1'b1;
        runCycles(20);
        bus.m3forceStopI = 1'b0;
        runCycles(300);

        // Run enable dropped mid-slice.
        waitRunAt(40, -1, 200);
        bus.workingI = 1'b0;
        runCycles(3);
        bus.workingI = 1'b1;
        runCycles(200);

        // Round wrap with a simultaneous direction change: dead slice, no nextCalc.
        waitRunAt(90, 5, 1200);
        bus.m3invRotateI = 1'b1;
        runCycles(400);

        // Randomized stretch.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) bus.m3invRotateI = ~bus.m3invRotateI;
            if ($urandom_range(0, 399) == 0) bus.m3forceStopI = 1'b1;
            else if (bus.m3forceStopI && $urandom_range(0, 7) == 0) bus.m3forceStopI = 1'b0;
            if ($urandom_range(0, 699) == 0) bus.workingI = ~bus.workingI;
            else if (!bus.workingI && $urandom_range(0, 9) == 0) bus.workingI = 1'b1;
            if ($urandom_range(0, 79) == 0) begin
                if ($urandom_range(0, 15) == 0) bus.dstRoundLenI = $urandom;
                else bus.dstRoundLenI = 32'($urandom_range(1, 150));
            end
            cycle();
        end

        // Asynchronous reset in the middle of a slice.
        setInputs(1'b0, 1'b0, 1'b0, 32'd100);
        runCycles(2);
        bus.workingI = 1'b1;
        runCycles(150);
        #2 nRstI = 1'b0;
        #1 checkVec("async_reset", actualVec(), resetVec);
        modelReset();
        exp_q.delete();
        @(posedge clkI);
        @(negedge clkI);
        checkVec("reset_hold", actualVec(), resetVec);
        nRstI = 1'b1;
        runCycles(700);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/m3_sliceperiodgen.md
# m3_slicePeriodGen

Commutation slice timer for motor 3: consumes the target slice period `dstRoundLenI` from the speed inc/dec calculator. Divides `clkI` into six-slice electrical rounds and steps the commutation phase index. Returns a one-cycle `nextCalc_1O` pulse per completed round, which closes the speed-ramp loop. Sits between the speed calculator and the phase-drive/PWM stage.

## Interface
Parameters (shared defines, not module parameters):
- `` `eachSlicePeriodMax `` — shared include; maximum slice period in clkI cycles; reset/idle period.
- `` `clkPeriodMin `` — 22'd40; minimum slice period in clkI cycles.

Ports:
- `clkI` in 1 — system clock; single clock domain.
- `nRstI` in 1 — reset, asynchronous, active-low.
- `workingI` in 1 — run enable; 0 forces IDLE.
- `m3forceStopI` in 1 — emergency stop; drive disabled while high.
- `m3invRotateI` in 1 — 1 = reverse phase sequence.
- `dstRoundLenI` in 32 — target slice period, clkI cycles.
- `nextCalc_1O` out 1 — one-cycle pulse at each round completion.
- `sliceTick_1O` out 1 — one-cycle pulse at each slice boundary.
- `phaseIdxO` out 3 — commutation phase, 0..5.
- `driveEnO` out 1 — 1 = phase stage may drive.
- `curPeriodO` out 32 — period of the slice in progress.

## Operation
- States: IDLE, RUN, DEAD, STOP.
- Priority, highest first: `workingI`=0 → IDLE; `m3forceStopI`=1 → STOP; normal transitions.
- IDLE:
  - phaseIdxO=0, driveEnO=0, slice counter 0, round slice count 0.
  - curPeriodO=`` `eachSlicePeriodMax ``.
  - Direction register loads `m3invRotateI`.
  - Goes to RUN when `workingI`=1 and `m3forceStopI`=0.
- Period latch:
  - Happens on IDLE→RUN and at every slice boundary.
  - curPeriodO = clamp(dstRoundLenI, `` `clkPeriodMin ``, `` `eachSlicePeriodMax ``).
  - Down-counter loads curPeriodO−1.
  - A dstRoundLenI change mid-slice has no effect until the next boundary.
- RUN: counter decrements each cycle. At count 0 (slice boundary):
  - Assert sliceTick_1O.
  - If `m3invRotateI` equals the direction register: advance phaseIdxO (+1 mod 6 forward, −1 mod 6 reverse) and increment the round slice count 0..5. On wrap 5→0, assert nextCalc_1O.
  - Otherwise: go to DEAD; phase and round count are held.
- DEAD:
  - One full slice with driveEnO=0 and phase held.
  - At its boundary: direction register loads `m3invRotateI`, round slice count clears to 0, go to RUN.
  - No nextCalc_1O pulse in DEAD.
- STOP:
  - driveEnO=0; counter cleared; phase held.
  - Goes to IDLE when `m3forceStopI`=0. A restart always passes through IDLE (phase 0).
- Arithmetic:
  - 32-bit unsigned compares for the clamp.
  - The counter never underflows; a reload always follows count 0.

## Timing
- Reset values: state IDLE, phaseIdxO=0, driveEnO=0, sliceTick_1O=0, nextCalc_1O=0, curPeriodO=`` `eachSlicePeriodMax ``, direction=0.
- All outputs are registered.
- IDLE→RUN: driveEnO=1 and curPeriodO valid on the cycle after the enabling edge.
- Slice length is exactly curPeriodO clkI cycles. sliceTick_1O and the phaseIdxO update appear in the same cycle.
- nextCalc_1O coincides with the sliceTick_1O that wraps the round. Period: 6×period cycles at constant period.
- `m3forceStopI` or `workingI`=0 drives driveEnO to 0 on the next clock edge, mid-slice included. Any pending tick/nextCalc pulse is suppressed.
- Simultaneous direction change and round wrap: DEAD wins; no nextCalc_1O.
- Asynchronous reset mid-slice: immediate return to reset values.

## Structure
- `` `clkPeriodMin `` moves into the shared define include next to `` `eachSlicePeriodMax ``, so calculator and generator use one value.
- State encoding defines (IDLE/RUN/DEAD/STOP) are local to the module.
- Sub-module: `m3_periodClamp` (combinational clamp), reusable by the calculator.
- Otherwise one flat module with a single state register process.

## Test plan
- Basic timing: dstRoundLenI=100, workingI 0→1 → sliceTick_1O every 100 cycles; phase 0,1,2,3,4,5,0; nextCalc_1O every 600 cycles.
- Clamping: dstRoundLenI=10 → curPeriodO=40. dstRoundLenI=`` `eachSlicePeriodMax ``+1 → curPeriodO=`` `eachSlicePeriodMax ``.
- Mid-slice period change: change 100→60 at cycle 50 of a slice → that slice stays 100 cycles; next slice is 60.
- Direction change: m3invRotateI 0→1 at phase 3 → one 100-cycle slice with driveEnO=0 and phase 3 held; then phases 2,1,0,5…; nextCalc_1O six slices after DEAD ends.
- Force stop: m3forceStopI=1 at cycle 30 of a slice → driveEnO=0 next cycle, no ticks. Release → IDLE then RUN; phaseIdxO=0.
- Enable and reset: workingI=0 mid-slice → IDLE values next cycle. nRstI low mid-slice → all reset values asynchronously.
